spi_dbg_slave: RTL and testbench

SPI_DBG_SLAVE -- requirements
Module: spi_dbg_slave

---
 rtl/spi_dbg_slave.sv | 106 ++++++++++
 tb/tb_spi_dbg_slave.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/spi_dbg_slave.sv
// SPI mode-3 debug slave. Each frame is an 8-bit command followed by DATA_W data bits.
// It reads back one of N_REGS words and commits writes to addresses that are writable.
module spi_dbg_slave #(
  parameter int                    DATA_W  = 16,
  parameter int                    ADDR_W  = 3,
  parameter logic [2**ADDR_W-1:0]  WR_MASK = 8'h80
) (
  input  logic                            sclk_i,
  input  logic                            resetb,
  input  logic                            csb_i,
  input  logic                            si_i,
  output logic                            so_o,
  input  logic [(2**ADDR_W)*DATA_W-1:0]   rd_data_i,
  output logic [DATA_W-1:0]               wr_data_o,
  output logic [ADDR_W-1:0]               wr_addr_o,
  output logic                            wr_toggle_o,
  output logic                            err_o
);

  localparam int N_REGS = 2**ADDR_W;
  localparam int F      = 8 + DATA_W;
  localparam int CNT_W  = $clog2(F + 1);

  localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(F - 1);
  localparam logic [CNT_W-1:0] CNT_END      = CNT_W'(F);

  logic [DATA_W-1:0] rd_words [N_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_rd_words
      assign rd_words[gi] = rd_data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic              frame_rstb;
  logic              armed_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [7:0]        cmd_reg;
  logic [DATA_W-1:0] din_reg;
  logic [DATA_W-1:0] dout_reg;
  logic [7:0]        cmd_next;
  logic [DATA_W-1:0] din_next;
  logic [ADDR_W-1:0] cmd_addr;

  // Frame state is held clear while the chip is deselected or in reset.
  assign frame_rstb = resetb & ~csb_i;
  assign cmd_next   = {cmd_reg[6:0], si_i};
  assign din_next   = {din_reg[DATA_W-2:0], si_i};
  assign cmd_addr   = cmd_reg[ADDR_W-1:0];

  // A falling csb edge seen after reset arms the slave, so a reset released
  // mid-frame ignores the remainder of that frame.
  always_ff @(negedge csb_i or negedge resetb) begin
    if (!resetb) armed_reg <= 1'b0;
    else         armed_reg <= 1'b1;
  end

  always_ff @(posedge sclk_i or negedge frame_rstb) begin
    if (!frame_rstb) begin
      cnt_reg <= '0;
      cmd_reg <= '0;
      din_reg <= '0;
    end else if (armed_reg && cnt_reg != CNT_END) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (cnt_reg < CNT_LOAD) cmd_reg <= cmd_next;
      else                    din_reg <= din_next;
    end
  end

  always_ff @(posedge sclk_i or negedge resetb) begin
    if (!resetb) begin
      wr_data_o   <= '0;
      wr_addr_o   <= '0;
      wr_toggle_o <= 1'b0;
      err_o       <= 1'b0;
    end else if (armed_reg && !csb_i) begin
      if (cnt_reg == CNT_CMD_LAST && cmd_next[6]) err_o <= 1'b0;
      if (cnt_reg == CNT_LAST && cmd_reg[7]) begin
        if (WR_MASK[cmd_addr]) begin
          wr_data_o   <= din_next;
          wr_addr_o   <= cmd_addr;
          wr_toggle_o <= ~wr_toggle_o;
        end else begin
          err_o <= 1'b1;
        end
      end
    end
  end

  // Read data is captured once, on the falling edge after the command completes.
  always_ff @(negedge sclk_i or negedge frame_rstb) begin
    if (!frame_rstb)                               dout_reg <= '0;
    else if (cnt_reg == CNT_LOAD)                  dout_reg <= rd_words[cmd_addr];
    else if (cnt_reg > CNT_LOAD && cnt_reg < CNT_END) dout_reg <= dout_reg << 1;
    else                                           dout_reg <= '0;
  end

  assign so_o = dout_reg[DATA_W-1] & ~csb_i;

  logic unused_bits;
  assign unused_bits = ^{cmd_reg, din_reg[DATA_W-1]};

endmodule

// File: tb/tb_spi_dbg_slave.sv
// Directed bench for spi_dbg_slave: a vector table of full frames plus
// hand-written abort, CLR_ERR, late rd_data change and mid-frame reset sequences.
module tb_spi_dbg_slave;

  logic         sclk_i;
  logic         resetb;
  logic         csb_i;
  logic         si_i;
  logic         so_o;
  logic [127:0] rd_data_i;
  logic [15:0]  wr_data_o;
  logic [2:0]   wr_addr_o;
  logic         wr_toggle_o;
  logic         err_o;

  spi_dbg_slave #(.DATA_W(16), .ADDR_W(3), .WR_MASK(8'h80)) dut (
    .sclk_i(sclk_i), .resetb(resetb), .csb_i(csb_i), .si_i(si_i), .so_o(so_o),
    .rd_data_i(rd_data_i), .wr_data_o(wr_data_o), .wr_addr_o(wr_addr_o),
    .wr_toggle_o(wr_toggle_o), .err_o(err_o)
  );

  logic [15:0] words [8];
  always_comb begin
    rd_data_i = '0;
    for (int k = 0; k < 8; k++) rd_data_i[k*16 +: 16] = words[k];
  end

  int          tests = 0;
  int          fails = 0;
  logic [40:1] so_cap;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    int          nclk;
    logic [15:0] exp_so;
    logic [15:0] exp_wd;
    logic [2:0]  exp_wa;
    logic        exp_tg;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // One SPI bit per call: si changes with the falling edge, so_o is sampled
  // just before the rising edge.
  task automatic shift_bits(input logic [7:0] cmd, input logic [15:0] data,
                            input int nclk, input int glitch_at);
    so_cap = '0;
    for (int i = 1; i <= nclk; i++) begin
      sclk_i = 1'b0;
      si_i   = (i <= 8) ? cmd[8-i] : ((i <= 24) ? data[24-i] : 1'b0);
      #4 so_cap[i] = so_o;
      #1 sclk_i = 1'b1;
      #5;
      if (i == glitch_at) words[2] = 16'h0000;
    end
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [15:0] data, input int nclk);
    csb_i = 1'b0;
    #5;
    shift_bits(cmd, data, nclk, -1);
    csb_i = 1'b1;
    #5;
  endtask

  function automatic logic [15:0] so_word();
    logic [15:0] w = '0;
    for (int b = 9; b <= 24; b++) w = {w[14:0], so_cap[b]};
    return w;
  endfunction

  initial begin
    sclk_i = 1'b1; csb_i = 1'b1; si_i = 1'b0; resetb = 1'b0;
    words[0] = 16'h1234; words[1] = 16'hBEEF; words[2] = 16'hA5C3; words[3] = 16'h3333;
    words[4] = 16'h4C4C; words[5] = 16'h0F0F; words[6] = 16'h6006; words[7] = 16'h7E57;

    vecs[0] = '{8'h02, 16'h0000, 24, 16'hA5C3, 16'h0000, 3'd0, 1'b0, 1'b0};
    vecs[1] = '{8'h87, 16'h0003, 24, 16'h7E57, 16'h0003, 3'd7, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 16'hFFFF, 24, 16'hBEEF, 16'h0003, 3'd7, 1'b1, 1'b1};
    vecs[3] = '{8'h40, 16'h0000, 24, 16'h1234, 16'h0003, 3'd7, 1'b1, 1'b0};
    vecs[4] = '{8'hA7, 16'hC0DE, 24, 16'h7E57, 16'hC0DE, 3'd7, 1'b0, 1'b0};
    vecs[5] = '{8'hC3, 16'h1111, 24, 16'h3333, 16'hC0DE, 3'd7, 1'b0, 1'b1};
    vecs[6] = '{8'h05, 16'hFFFF, 30, 16'h0F0F, 16'hC0DE, 3'd7, 1'b0, 1'b1};
    vecs[7] = '{8'hC7, 16'h5A5A, 24, 16'h7E57, 16'h5A5A, 3'd7, 1'b1, 1'b0};
    vecs[8] = '{8'h04, 16'h0000, 24, 16'h4C4C, 16'h5A5A, 3'd7, 1'b1, 1'b0};

    #20;
    check("rst so_o", 32'(so_o), 32'h0);
    check("rst wr_data", 32'(wr_data_o), 32'h0);
    check("rst wr_addr", 32'(wr_addr_o), 32'h0);
    check("rst toggle", 32'(wr_toggle_o), 32'h0);
    check("rst err", 32'(err_o), 32'h0);
    resetb = 1'b1;
    #10;

    for (int v = 0; v < 9; v++) begin
      frame(vecs[v].cmd, vecs[v].data, vecs[v].nclk);
      check($sformatf("v%0d cmd-phase so", v), 32'(so_cap[8:1]), 32'h0);
      check($sformatf("v%0d so data", v), 32'(so_word()), 32'(vecs[v].exp_so));
      if (vecs[v].nclk > 24)
        check($sformatf("v%0d extra so", v), 32'(so_cap[40:25]), 32'h0);
      check($sformatf("v%0d wr_data", v), 32'(wr_data_o), 32'(vecs[v].exp_wd));
      check($sformatf("v%0d wr_addr", v), 32'(wr_addr_o), 32'(vecs[v].exp_wa));
      check($sformatf("v%0d toggle", v), 32'(wr_toggle_o), 32'(vecs[v].exp_tg));
      check($sformatf("v%0d err", v), 32'(err_o), 32'(vecs[v].exp_err));
      check($sformatf("v%0d idle so", v), 32'(so_o), 32'h0);
    end

    // Error set, then CLR_ERR visible right after edge 8 and kept on abort.
    frame(8'h81, 16'h0000, 24);
    check("err set", 32'(err_o), 32'h1);
    csb_i = 1'b0; #5;
    shift_bits(8'h40, 16'h0000, 8, -1);
    check("clr at edge 8", 32'(err_o), 32'h0);
    csb_i = 1'b1; #5;
    check("clr after abort", 32'(err_o), 32'h0);

    // Aborted write after 12 edges must not commit; next read is clean.
    frame(8'h87, 16'hAAAA, 12);
    check("abort so idle", 32'(so_o), 32'h0);
    check("abort toggle", 32'(wr_toggle_o), 32'h1);
    check("abort wr_data", 32'(wr_data_o), 32'h5A5A);
    frame(8'h00, 16'h0000, 24);
    check("post-abort read", 32'(so_word()), 32'h1234);

    // rd_data changes after the load edge do not disturb the shifted word.
    csb_i = 1'b0; #5;
    shift_bits(8'h02, 16'h0000, 24, 10);
    csb_i = 1'b1; #5;
    check("late rd change", 32'(so_word()), 32'hA5C3);
    words[2] = 16'hA5C3;

    // Reset mid-frame at edge 15, then unarmed clocks, then a clean write.
    frame(8'h81, 16'h0000, 24);
    csb_i = 1'b0; #5;
    shift_bits(8'h87, 16'h0F00, 15, -1);
    check("pre-reset so", 32'(so_o), 32'h1);
    resetb = 1'b0;
    #1;
    check("mid rst so_o", 32'(so_o), 32'h0);
    check("mid rst wr_data", 32'(wr_data_o), 32'h0);
    check("mid rst wr_addr", 32'(wr_addr_o), 32'h0);
    check("mid rst toggle", 32'(wr_toggle_o), 32'h0);
    check("mid rst err", 32'(err_o), 32'h0);
    #4 resetb = 1'b1;
    #5;
    shift_bits(8'h87, 16'hFFFF, 24, -1);
    csb_i = 1'b1; #5;
    check("unarmed toggle", 32'(wr_toggle_o), 32'h0);
    check("unarmed wr_data", 32'(wr_data_o), 32'h0);
    frame(8'h87, 16'h0003, 24);
    check("post-rst wr_data", 32'(wr_data_o), 32'h0003);
    check("post-rst wr_addr", 32'(wr_addr_o), 32'h7);
    check("post-rst toggle", 32'(wr_toggle_o), 32'h1);
    check("post-rst err", 32'(err_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
